// File: rtl/pio_pkg.sv
// Shared PIO definitions used by the shift registers.
//   SHIFT_RIGHT / SHIFT_LEFT : values of the dir control
//   COUNT_EMPTY              : shift count value meaning "register fully consumed"
//   decode_count()           : 5-bit count field where 0 encodes 32
package pio_pkg;

  localparam logic SHIFT_RIGHT = 1'b1;
  localparam logic SHIFT_LEFT  = 1'b0;

  localparam logic [5:0] COUNT_EMPTY = 6'd32;

  function automatic logic [5:0] decode_count(input logic [4:0] f);
    return (f == 5'd0) ? 6'd32 : {1'b0, f};
  endfunction

endpackage

// File: rtl/osr_shifter.sv
// Combinational OUT datapath for the output shift register.
//   src  : word being shifted out of
//   dir  : 1 = right (LSB first), 0 = left (MSB first)
//   sv   : shift amount 1..32
//   dout : bits shifted out, right-aligned, unused bits zero
//   next : remaining word after the shift (zero when sv = 32)
module osr_shifter
  import pio_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] src,
  input  logic          dir,
  input  logic [5:0]    sv,
  output logic [DW-1:0] dout,
  output logic [DW-1:0] next
);

  logic          full;
  logic [DW-1:0] mask;

  // A 32-bit shift needs its own path: shifting a 32-bit word by 32 is
  // avoided so the result does not depend on shift-width semantics.
  assign full = (sv >= 6'd32);
  assign mask = full ? '1 : ((DW'(1) << sv) - DW'(1));

  always_comb begin
    dout = '0;
    next = '0;
    if (dir == SHIFT_RIGHT) begin
      dout = src & mask;
      next = full ? '0 : (src >> sv);
    end else begin
      // For sv = 32 the subtraction wraps to 0 and the whole word comes out.
      dout = src >> (6'd32 - sv);
      next = full ? '0 : (src << sv);
    end
  end

endmodule

// File: rtl/osr.sv
// Output shift register for one PIO state machine.
//   clk, reset          : clock, synchronous active-high reset
//   penable, stalled    : update qualifiers (clock divider, other stall source)
//   dir, shift          : OUT direction and bit count (0 = 32)
//   pull_thresh,autopull: autopull / PULL IFEMPTY threshold (0 = 32) and enable
//   do_out/do_pull/do_set, pull_block, pull_ifempty : instruction decode
//   din                 : MOV source / non-blocking PULL fallback value
//   fifo_data,fifo_empty: TX FIFO head
//   fifo_pop            : one-cycle pop strobe (committed updates only)
//   dout                : OUT data, right-aligned
//   stall               : current instruction must re-execute
//   osr_q, shift_count  : register contents and bits consumed (32 = empty)
module osr
  import pio_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          penable,
  input  logic          stalled,
  input  logic          dir,
  input  logic [4:0]    shift,
  input  logic [4:0]    pull_thresh,
  input  logic          autopull,
  input  logic          do_out,
  input  logic          do_pull,
  input  logic          pull_block,
  input  logic          pull_ifempty,
  input  logic          do_set,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] fifo_data,
  input  logic          fifo_empty,
  output logic          fifo_pop,
  output logic [DW-1:0] dout,
  output logic          stall,
  output logic [DW-1:0] osr_q,
  output logic [5:0]    shift_count
);

  logic [5:0]    sv, th;
  logic          exhausted, refill, update;
  logic [DW-1:0] src, sh_next;
  logic [5:0]    base;
  logic [6:0]    sum;
  logic [5:0]    out_cnt;

  logic          pop_d, stall_d, load;
  logic [DW-1:0] nxt_osr;
  logic [5:0]    nxt_cnt;

  assign sv        = decode_count(shift);
  assign th        = decode_count(pull_thresh);
  assign exhausted = (shift_count >= th);
  assign update    = penable && !stalled && !reset;

  // OUT with autopull on an exhausted register shifts straight out of the
  // FIFO head word, counting from zero.
  assign refill = autopull && exhausted && !fifo_empty;
  assign src    = refill ? fifo_data : osr_q;
  assign base   = refill ? 6'd0 : shift_count;

  osr_shifter #(.DW(DW)) u_shifter (
    .src  (src),
    .dir  (dir),
    .sv   (sv),
    .dout (dout),
    .next (sh_next)
  );

  assign sum     = {1'b0, base} + {1'b0, sv};
  assign out_cnt = (sum > 7'd32) ? COUNT_EMPTY : sum[5:0];

  always_comb begin
    pop_d   = 1'b0;
    stall_d = 1'b0;
    load    = 1'b0;
    nxt_osr = osr_q;
    nxt_cnt = shift_count;
    if (do_set) begin
      load    = 1'b1;
      nxt_osr = din;
      nxt_cnt = 6'd0;
    end else if (do_pull) begin
      if ((pull_ifempty || autopull) && !exhausted) begin
        // still holding enough data: PULL is a no-op
      end else if (!fifo_empty) begin
        pop_d   = 1'b1;
        load    = 1'b1;
        nxt_osr = fifo_data;
        nxt_cnt = 6'd0;
      end else if (pull_block) begin
        stall_d = 1'b1;
      end else begin
        load    = 1'b1;
        nxt_osr = din;
        nxt_cnt = 6'd0;
      end
    end else if (do_out) begin
      if (autopull && exhausted && fifo_empty) begin
        stall_d = 1'b1;
      end else begin
        pop_d   = refill;
        load    = 1'b1;
        nxt_osr = sh_next;
        nxt_cnt = out_cnt;
      end
    end else if (refill) begin
      pop_d   = 1'b1;
      load    = 1'b1;
      nxt_osr = fifo_data;
      nxt_cnt = 6'd0;
    end
  end

  assign fifo_pop = pop_d && update;
  assign stall    = stall_d && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      osr_q       <= '0;
      shift_count <= COUNT_EMPTY;
    end else if (update && load) begin
      osr_q       <= nxt_osr;
      shift_count <= nxt_cnt;
    end
  end

endmodule

// File: tb/tb_osr.sv
module tb_osr;

  logic        clk = 1'b0;
  logic        reset, penable, stalled, dir, autopull;
  logic [4:0]  shift, pull_thresh;
  logic        do_out, do_pull, pull_block, pull_ifempty, do_set;
  logic [31:0] din, fifo_data;
  logic        fifo_empty;
  logic        fifo_pop, stall;
  logic [31:0] dout, osr_q;
  logic [5:0]  shift_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  osr dut (
    .clk(clk), .reset(reset), .penable(penable), .stalled(stalled),
    .dir(dir), .shift(shift), .pull_thresh(pull_thresh), .autopull(autopull),
    .do_out(do_out), .do_pull(do_pull), .pull_block(pull_block),
    .pull_ifempty(pull_ifempty), .do_set(do_set), .din(din),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .dout(dout), .stall(stall), .osr_q(osr_q), .shift_count(shift_count)
  );

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_valid = 1'b0;
  longint unsigned m_osr, m_cnt;

  function automatic longint unsigned p2(input int n);
    return 64'd1 << n;
  endfunction

  // Checks DUT against the model mid-cycle, then advances the model to the
  // state the coming clock edge must produce.
  always @(negedge clk) begin
    int              sv, th;
    bit              exh, upd, e_pop, e_stall, chk_dout, ld;
    longint unsigned src, base, e_dout, n_osr, n_cnt;
    sv = (shift == 0) ? 32 : int'(shift);
    th = (pull_thresh == 0) ? 32 : int'(pull_thresh);
    exh = (m_cnt >= th);
    upd = penable && !stalled;
    e_pop = 0; e_stall = 0; chk_dout = 0; ld = 0;
    e_dout = 0; n_osr = m_osr; n_cnt = m_cnt;
    if (do_set) begin
      ld = 1; n_osr = din; n_cnt = 0;
    end else if (do_pull) begin
      if ((pull_ifempty || autopull) && !exh) ;
      else if (!fifo_empty) begin e_pop = 1; ld = 1; n_osr = fifo_data; n_cnt = 0; end
      else if (pull_block) e_stall = 1;
      else begin ld = 1; n_osr = din; n_cnt = 0; end
    end else if (do_out) begin
      if (autopull && exh && fifo_empty) e_stall = 1;
      else begin
        src = m_osr; base = m_cnt;
        if (autopull && exh) begin src = fifo_data; base = 0; e_pop = 1; end
        if (dir) begin
          e_dout = src % p2(sv);
          n_osr  = src / p2(sv);
        end else begin
          e_dout = src / p2(32 - sv);
          n_osr  = (src * p2(sv)) % p2(32);
        end
        n_cnt = (base + sv > 32) ? 32 : base + sv;
        chk_dout = 1; ld = 1;
      end
    end else if (autopull && exh && !fifo_empty) begin
      e_pop = 1; ld = 1; n_osr = fifo_data; n_cnt = 0;
    end
    if (!upd) begin e_pop = 0; ld = 0; end
    if (reset) begin e_pop = 0; e_stall = 0; chk_dout = 0; end
    if (m_valid) begin
      chk("fifo_pop", fifo_pop, e_pop);
      chk("stall", stall, e_stall);
      chk("osr_q", osr_q, m_osr);
      chk("shift_count", shift_count, m_cnt);
      if (chk_dout) chk("dout", dout, e_dout);
    end
    if (reset) begin
      m_valid = 1; m_osr = 0; m_cnt = 32;
    end else if (ld) begin
      m_osr = n_osr; m_cnt = n_cnt;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    reset = 0; penable = 1; stalled = 0; dir = 1; shift = 0; pull_thresh = 0;
    autopull = 0; do_out = 0; do_pull = 0; pull_block = 0; pull_ifempty = 0;
    do_set = 0; din = 0; fifo_data = 0; fifo_empty = 1;
  endtask

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    chk("reset osr_q", osr_q, 0);
    chk("reset count", shift_count, 32);
    chk("reset pop", fifo_pop, 0);
    idle();

    // MOV then right OUT 8
    do_set = 1; din = 32'h12345678; tick(); idle();
    do_out = 1; dir = 1; shift = 8; #1;
    chk("right dout", dout, 32'h78);
    tick(); idle();
    chk("right osr_q", osr_q, 32'h00123456);
    chk("right count", shift_count, 8);

    // MOV then left OUT 4
    do_set = 1; din = 32'hA5000000; tick(); idle();
    do_out = 1; dir = 0; shift = 4; #1;
    chk("left dout", dout, 32'hA);
    tick(); idle();
    chk("left osr_q", osr_q, 32'h50000000);
    chk("left count", shift_count, 4);

    // full-width OUT saturates the count
    do_out = 1; dir = 0; shift = 0; #1;
    chk("full dout", dout, 32'h50000000);
    tick();
    chk("full count", shift_count, 32);
    chk("full osr_q", osr_q, 0);
    tick(); idle();
    chk("full again count", shift_count, 32);

    // autopull stall on empty FIFO, then refill from FIFO
    do_set = 1; din = 32'h11223344; tick(); idle();
    do_out = 1; dir = 1; shift = 8; tick(); idle();
    autopull = 1; pull_thresh = 8; do_out = 1; dir = 1; shift = 8; fifo_empty = 1; #1;
    chk("autopull stall", stall, 1);
    chk("autopull no pop", fifo_pop, 0);
    tick();
    chk("autopull held osr", osr_q, 32'h00112233);
    chk("autopull held cnt", shift_count, 8);
    fifo_data = 32'hDEADBEEF; fifo_empty = 0; #1;
    chk("autopull pop", fifo_pop, 1);
    chk("autopull dout", dout, 32'hEF);
    tick(); idle();
    chk("autopull osr_q", osr_q, 32'h00DEADBE);
    chk("autopull count", shift_count, 8);

    // PULL variants
    do_out = 1; shift = 0; tick(); idle();
    do_pull = 1; fifo_empty = 1; din = 32'h55; #1;
    chk("nb pull pop", fifo_pop, 0);
    tick(); idle();
    chk("nb pull osr_q", osr_q, 32'h55);
    chk("nb pull count", shift_count, 0);
    do_pull = 1; pull_block = 1; fifo_empty = 1; #1;
    chk("blk pull stall", stall, 1);
    tick(); idle();
    chk("blk pull held", osr_q, 32'h55);
    do_pull = 1; pull_ifempty = 1; pull_thresh = 0; fifo_empty = 0; fifo_data = 32'h99; #1;
    chk("ifempty no pop", fifo_pop, 0);
    tick(); idle();
    chk("ifempty held", osr_q, 32'h55);
    do_pull = 1; penable = 0; fifo_empty = 0; fifo_data = 32'h77; #1;
    chk("penable0 no pop", fifo_pop, 0);
    tick(); idle();
    chk("penable0 held", osr_q, 32'h55);
    chk("penable0 cnt", shift_count, 0);

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      idle();
      r = $urandom_range(0, 9);
      do_set  = (r == 0);
      do_pull = (r == 1 || r == 2);
      do_out  = (r >= 3 && r <= 6);
      penable = ($urandom_range(0, 9) != 0);
      stalled = ($urandom_range(0, 9) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      dir = $urandom_range(0, 1);
      shift = 5'($urandom);
      pull_thresh = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      autopull = $urandom_range(0, 1);
      pull_block = $urandom_range(0, 1);
      pull_ifempty = $urandom_range(0, 1);
      din = $urandom;
      fifo_data = $urandom;
      fifo_empty = ($urandom_range(0, 2) == 0);
      tick();
    end
    idle();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
